// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample scheduler slice.
package i2s_pkg;

   typedef enum logic [1:0] {
      MODE_A    = 2'b00,
      MODE_B    = 2'b01,
      MODE_PRIO = 2'b10,
      MODE_MIX  = 2'b11
   } src_mode_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ARB    = 2'b01,
      HELD   = 2'b10,
      COMMIT = 2'b11
   } sched_state_t;

   localparam int unsigned FRAME_SLOTS = 32;
   localparam int unsigned LAST_SLOT   = FRAME_SLOTS - 1;
   localparam int unsigned SAMPLE_W    = 16;

   localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 16'h7FFF;
   localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = 16'h8000;

   // Two's-complement add clamped to the 16-bit sample range.
   function automatic logic [SAMPLE_W-1:0] sat_add(input logic [SAMPLE_W-1:0] a,
                                                   input logic [SAMPLE_W-1:0] b);
      logic [SAMPLE_W:0] sum;
      sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
      if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
         return sum[SAMPLE_W] ? SAMPLE_MIN : SAMPLE_MAX;
      end
      return sum[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Divides dac_mclk to the registered serial bit clock; rise flags the edge
// on which serial_clk goes 0->1 so callers can act on that same edge.
module i2s_clk_div #(
   parameter int unsigned MCLK_DIV = 4
) (
   input  logic dac_mclk,
   input  logic reset,
   output logic serial_clk,
   output logic rise
);

   localparam int unsigned HALF = MCLK_DIV / 2;
   localparam int unsigned CW   = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;

   logic [CW-1:0] r_div_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_serial_clk;

   assign w_cnt_nxt = (r_div_cnt == CW'(MCLK_DIV - 1)) ? '0 : r_div_cnt + CW'(1);

   always_ff @(posedge dac_mclk or negedge reset) begin
      if (!reset) begin
         r_div_cnt    <= '0;
         r_serial_clk <= 1'b0;
      end else begin
         r_div_cnt    <= w_cnt_nxt;
         r_serial_clk <= (w_cnt_nxt >= CW'(HALF));
      end
   end

   assign serial_clk = r_serial_clk;
   assign rise       = (w_cnt_nxt == CW'(HALF));

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Frame-position tracking, source arbitration/mixing and commit sequencing
// for the I2S transmit path.
module i2s_sample_scheduler
   import i2s_pkg::*;
#(
   parameter int unsigned MCLK_DIV      = 4,
   parameter int unsigned FETCH_SLOT    = 16,
   parameter bit          UNDERRUN_HOLD = 1'b1,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                dac_mclk,
   input  logic                reset,
   input  logic                tx_enable,
   input  logic [1:0]          mode,
   input  logic                a_valid,
   input  logic [SAMPLE_W-1:0] a_data,
   output logic                a_ready,
   input  logic                b_valid,
   input  logic [SAMPLE_W-1:0] b_data,
   output logic                b_ready,
   output logic                serial_clk,
   output logic [4:0]          frame_pos,
   output logic [SAMPLE_W-1:0] sound_out,
   output logic                frame_strobe,
   output logic                underrun,
   output logic [CNT_W-1:0]    underrun_count
);

   logic                w_rise;
   logic [4:0]          r_frame_pos;
   logic [4:0]          w_pos_nxt;
   sched_state_t        r_state;
   sched_state_t        w_state_nxt;
   src_mode_t           r_mode_q;
   src_mode_t           w_mode_nxt;
   logic                r_stage_a_vld;
   logic                r_stage_b_vld;
   logic [SAMPLE_W-1:0] r_stage_a;
   logic [SAMPLE_W-1:0] r_stage_b;
   logic [SAMPLE_W-1:0] r_last;
   logic [SAMPLE_W-1:0] r_sound;
   logic                r_a_rdy;
   logic                r_b_rdy;
   logic                r_strobe;
   logic                r_underrun;
   logic [CNT_W-1:0]    r_ucnt;

   logic                w_open;
   logic                w_commit;
   logic                w_a_xfer;
   logic                w_b_xfer;
   logic                w_a_have;
   logic                w_b_have;
   logic [SAMPLE_W-1:0] w_a_val;
   logic [SAMPLE_W-1:0] w_b_val;
   logic                w_done;
   logic                w_stage_a_vld_nxt;
   logic                w_stage_b_vld_nxt;
   logic                w_a_rdy_nxt;
   logic                w_b_rdy_nxt;
   logic                w_short;
   logic [SAMPLE_W-1:0] w_commit_val;

   i2s_clk_div #(
      .MCLK_DIV (MCLK_DIV)
   ) u_clk_div (
      .dac_mclk   (dac_mclk),
      .reset      (reset),
      .serial_clk (serial_clk),
      .rise       (w_rise)
   );

   assign w_pos_nxt = r_frame_pos + 5'd1;

   always_ff @(posedge dac_mclk or negedge reset) begin
      if (!reset) begin
         r_frame_pos <= 5'(LAST_SLOT);
      end else if (w_rise) begin
         r_frame_pos <= w_pos_nxt;
      end
   end

   assign w_open   = w_rise && (w_pos_nxt == 5'(FETCH_SLOT)) && (r_state == IDLE);
   assign w_commit = w_rise && (w_pos_nxt == 5'(LAST_SLOT)) &&
                     ((r_state == ARB) || (r_state == HELD));

   // In priority mode B is only offered while A is not presenting.
   assign a_ready  = r_a_rdy;
   assign b_ready  = (r_mode_q == MODE_PRIO) ? (r_b_rdy & ~a_valid) : r_b_rdy;
   assign w_a_xfer = a_valid & a_ready;
   assign w_b_xfer = b_valid & b_ready;

   // A transfer on the commit edge itself still counts toward that commit.
   assign w_a_have = r_stage_a_vld | w_a_xfer;
   assign w_b_have = r_stage_b_vld | w_b_xfer;
   assign w_a_val  = w_a_xfer ? a_data : r_stage_a;
   assign w_b_val  = w_b_xfer ? b_data : r_stage_b;

   always_comb begin
      w_done = 1'b0;
      unique case (r_mode_q)
         MODE_A:    w_done = w_a_have;
         MODE_B:    w_done = w_b_have;
         MODE_PRIO: w_done = w_a_have | w_b_have;
         MODE_MIX:  w_done = w_a_have & w_b_have;
         default:   w_done = 1'b0;
      endcase
   end

   always_ff @(posedge dac_mclk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_mode_q <= MODE_A;
      end else begin
         r_state  <= w_state_nxt;
         r_mode_q <= w_mode_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode_q;
      unique case (r_state)
         IDLE: begin
            if (w_open) begin
               w_state_nxt = ARB;
               w_mode_nxt  = src_mode_t'(mode);
            end
         end
         ARB: begin
            if (w_commit)    w_state_nxt = COMMIT;
            else if (w_done) w_state_nxt = HELD;
         end
         HELD: begin
            if (w_commit) w_state_nxt = COMMIT;
         end
         COMMIT:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_stage_a_vld_nxt = w_commit ? 1'b0 : w_a_have;
   assign w_stage_b_vld_nxt = w_commit ? 1'b0 : w_b_have;

   assign w_a_rdy_nxt = (w_state_nxt == ARB) && tx_enable && !w_stage_a_vld_nxt &&
                        (w_mode_nxt != MODE_B);
   assign w_b_rdy_nxt = (w_state_nxt == ARB) && tx_enable && !w_stage_b_vld_nxt &&
                        (w_mode_nxt != MODE_A) &&
                        ((w_mode_nxt != MODE_PRIO) || !w_stage_a_vld_nxt);

   always_comb begin
      w_short      = 1'b0;
      w_commit_val = '0;
      if (tx_enable) begin
         unique case (r_mode_q)
            MODE_A: begin
               if (w_a_have) w_commit_val = w_a_val;
               else          w_short      = 1'b1;
            end
            MODE_B: begin
               if (w_b_have) w_commit_val = w_b_val;
               else          w_short      = 1'b1;
            end
            MODE_PRIO: begin
               if (w_a_have)      w_commit_val = w_a_val;
               else if (w_b_have) w_commit_val = w_b_val;
               else               w_short      = 1'b1;
            end
            MODE_MIX: begin
               if (w_a_have || w_b_have) begin
                  w_commit_val = sat_add(w_a_have ? w_a_val : '0,
                                         w_b_have ? w_b_val : '0);
               end else begin
                  w_short = 1'b1;
               end
            end
            default: w_short = 1'b0;
         endcase
         if (w_short) begin
            w_commit_val = UNDERRUN_HOLD ? r_last : '0;
         end
      end
   end

   always_ff @(posedge dac_mclk or negedge reset) begin
      if (!reset) begin
         r_stage_a_vld <= 1'b0;
         r_stage_b_vld <= 1'b0;
         r_stage_a     <= '0;
         r_stage_b     <= '0;
         r_a_rdy       <= 1'b0;
         r_b_rdy       <= 1'b0;
      end else begin
         r_stage_a_vld <= w_stage_a_vld_nxt;
         r_stage_b_vld <= w_stage_b_vld_nxt;
         if (w_a_xfer) r_stage_a <= a_data;
         if (w_b_xfer) r_stage_b <= b_data;
         r_a_rdy       <= w_a_rdy_nxt;
         r_b_rdy       <= w_b_rdy_nxt;
      end
   end

   always_ff @(posedge dac_mclk or negedge reset) begin
      if (!reset) begin
         r_sound    <= '0;
         r_last     <= '0;
         r_strobe   <= 1'b0;
         r_underrun <= 1'b0;
         r_ucnt     <= '0;
      end else begin
         r_strobe   <= w_commit;
         r_underrun <= w_commit && w_short;
         if (w_commit) begin
            r_sound <= w_commit_val;
            r_last  <= w_commit_val;
            if (w_short && (r_ucnt != '1)) begin
               r_ucnt <= r_ucnt + CNT_W'(1);
            end
         end
      end
   end

   assign frame_pos      = r_frame_pos;
   assign sound_out      = r_sound;
   assign frame_strobe   = r_strobe;
   assign underrun       = r_underrun;
   assign underrun_count = r_ucnt;

endmodule

// File: doc/i2s_sample_scheduler.md
Name: i2s_sample_scheduler

Overview:
- Controller that sequences the I2S transmit path from the DAC master clock.
- Divides dac_mclk down to serial_clk and tracks the 32-slot frame position in lock-step with the transmitter's bit counter.
- Arbitrates or mixes two 16-bit sample sources over valid/ready and presents one stable sample on sound_out for the transmitter to capture at frame end.
- Sits between the audio processing chain (source A), the tone/alert generator (source B) and the I2S transmitter.

Parameters:
- MCLK_DIV, 4, dac_mclk cycles per serial_clk period. Must be even and ≥2.
- FETCH_SLOT, 16, frame_pos value at which the fetch window opens. Legal range 0..29.
- UNDERRUN_HOLD, 1, 1 = repeat the last committed sample on underrun; 0 = output zero.
- CNT_W, 8, width of the saturating underrun counter.

Ports:
- dac_mclk  in  1  12.288 MHz master clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- tx_enable  in  1  0 forces silence at each commit and holds both readys low.
- mode  in  2  00 = A only, 01 = B only, 10 = priority A>B, 11 = mix A+B.
- a_valid, a_data  in  1, 16  source A handshake; a_data is signed.
- a_ready  out  1  source A accept.
- b_valid, b_data  in  1, 16  source B handshake; b_data is signed.
- b_ready  out  1  source B accept.
- serial_clk  out  1  bit clock to the DAC and transmitter; registered.
- frame_pos  out  5  mirror of the transmitter bit counter.
- sound_out  out  16  sample driven to transmitter sound_in.
- frame_strobe  out  1  one-cycle pulse on each commit.
- underrun  out  1  one-cycle pulse on commit with no sample.
- underrun_count  out  CNT_W  saturating underrun count.

Behaviour:
- Reset values: div_cnt 0, serial_clk 0, frame_pos 31, sound_out 0, a_ready/b_ready 0, frame_strobe 0, underrun 0, underrun_count 0, stage flags clear, last sample 0, state IDLE.
- Divider: div_cnt counts 0..MCLK_DIV-1 and wraps. serial_clk is high while div_cnt ≥ MCLK_DIV/2.
- rise pulse: asserted on the dac_mclk edge that takes serial_clk 0→1. First rise occurs on the 2nd dac_mclk edge after reset release (MCLK_DIV=4).
- frame_pos: advances on each rise edge, 31→0 wrap.
- States:
  - IDLE→ARB on the rise edge that makes frame_pos==FETCH_SLOT; mode is latched into mode_q at that edge.
  - ARB→HELD once every source required by mode_q has been accepted.
  - ARB or HELD→COMMIT on the rise edge that makes frame_pos==31.
  - COMMIT→IDLE after one cycle.
- Readys: asserted only in ARB with tx_enable=1 and the matching stage flag clear; registered from state, never dependent on ready.
  - Exception: in priority mode, b_ready = ARB & !a_valid & stage empty.
  - A transfer occurs on any edge with valid&ready; data goes into stage_a or stage_b.
- Modes (mode_q):
  - 00: accept A only.
  - 01: accept B only.
  - 10: accept A if valid, else B. First accepted sample ends ARB. If both are valid, A wins.
  - 11: accept A and B independently in ARB.
- Commit edge (frame_pos 30→31): sound_out and last sample are loaded; frame_strobe pulses. sound_out is then stable for all MCLK_DIV cycles of slot 31 and through the transmitter capture edge.
- Commit value:
  - tx_enable=0: 0.
  - Mix mode: signed saturating A+B, clamped to 16'h7FFF / 16'h8000. A missing source counts as 0.
  - Otherwise: the staged sample.
- Underrun: required sample(s) absent at commit (mix: both absent; tx_enable=1 only).
  - sound_out = last sample if UNDERRUN_HOLD=1, else 0.
  - underrun pulses; underrun_count increments and saturates at all-ones.
- Stage flags clear at commit. A valid arriving after 30→31 waits for the next window.
- Mode change outside the window takes effect at the next window open. tx_enable deasserted mid-ARB drops readys on the next edge; staged data is discarded at commit.
- Reset mid-frame: everything returns to reset values immediately; serial_clk goes low asynchronously.

Decomposition:
- Package i2s_pkg holds:
  - typedef src_mode_t with MODE_A, MODE_B, MODE_PRIO, MODE_MIX.
  - typedef sched_state_t with IDLE, ARB, HELD, COMMIT.
  - Constants FRAME_SLOTS=32, LAST_SLOT=31, SAMPLE_W=16, SAMPLE_MAX, SAMPLE_MIN.
- Sub-module i2s_clk_div(dac_mclk, reset → serial_clk, rise) for the divider.
- Arbitration, mixing and the FSM stay in the top level.

Test Plan:
- Reset release with tx_enable=0 → serial_clk first high on 2nd edge, period 4 cycles; frame_pos 31→0 on first rise; sound_out stays 0; frame_strobe every 128 cycles.
- mode=00, a_valid always high, a_data=16'h1234 → a_ready high from window open (frame_pos 16) for one transfer; sound_out=16'h1234 at frame_pos 30→31; underrun_count stays 0.
- mode=10, A and B valid in the same window (A=16'h0AAA, B=16'h0BBB) → A accepted, b_ready never high, commit 16'h0AAA. Next frame A idle → commit 16'h0BBB.
- mode=11, A=16'h7000, B=16'h2000 → commit 16'h7FFF. A=16'h9000, B=16'hA000 → commit 16'h8000. A=16'h0100 with B absent → commit 16'h0100, no underrun.
- mode=00, no valid for 300 frames, UNDERRUN_HOLD=1, last sample 16'h0042 → sound_out stays 16'h0042; underrun pulses each frame; underrun_count saturates at 255.
- Assert reset during ARB with a transfer in flight → all outputs return to reset values asynchronously. After release, no stale sample is committed; the first commit is an underrun with value 0.
